// File: rtl/issue_select_pkg.sv
// Shared constants and helpers for the issue-queue select stage.
package issue_select_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for an n-entry queue; a single-entry queue still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/issue_select_rr_sel_node.sv
// Two-input select-tree node: forwards the lower-index valid input.
module sel_node #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 5
) (
  input  logic             valid0,
  input  logic             valid1,
  input  logic [IDX_W-1:0] idx0,
  input  logic [IDX_W-1:0] idx1,
  input  logic [TAG_W-1:0] tag0,
  input  logic [TAG_W-1:0] tag1,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [TAG_W-1:0] tag
);

  assign valid = valid0 | valid1;
  assign idx   = valid0 ? idx0 : idx1;
  assign tag   = valid0 ? tag0 : tag1;

endmodule

// File: rtl/issue_select_rr.sv
// Registered issue select: binary select tree(s), optional round-robin pointer,
// and a valid/ready output register with a one-hot grant back to the queue.
module issue_select_rr
  import issue_select_pkg::*;
#(
  parameter int N     = 16,
  parameter int TAG_W = 5,
  parameter int MODE  = MODE_RR,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     req,
  input  logic [N*TAG_W-1:0] tag,
  input  logic             flush,
  output logic [N-1:0]     grant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NT = (MODE == MODE_RR) ? 2 : 1;

  logic [IDX_W-1:0]       ptr;
  logic [NT-1:0][N-1:0]   tree_req;
  logic                   any_req;
  logic                   use_hi;
  logic [IDX_W-1:0]       win_idx;
  logic [TAG_W-1:0]       win_tag;
  logic                   load_en;

  // Tree 0 sees every request; tree 1 (round-robin only) sees entries >= ptr.
  for (genvar t = 0; t < NT; t++) begin : g_tree
    for (genvar lv = 0; lv <= IDX_W; lv++) begin : g_lv
      logic             v  [1 << lv];
      logic [IDX_W-1:0] ix [1 << lv];
      logic [TAG_W-1:0] tg [1 << lv];
      if (lv == IDX_W) begin : g_leaf
        for (genvar i = 0; i < N; i++) begin : g_ent
          assign v[i]  = tree_req[t][i];
          assign ix[i] = IDX_W'(i);
          assign tg[i] = tag[i*TAG_W +: TAG_W];
        end
      end else begin : g_inner
        for (genvar j = 0; j < (1 << lv); j++) begin : g_node
          sel_node #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_node (
            .valid0 (g_lv[lv+1].v[2*j]),
            .valid1 (g_lv[lv+1].v[2*j+1]),
            .idx0   (g_lv[lv+1].ix[2*j]),
            .idx1   (g_lv[lv+1].ix[2*j+1]),
            .tag0   (g_lv[lv+1].tg[2*j]),
            .tag1   (g_lv[lv+1].tg[2*j+1]),
            .valid  (v[j]),
            .idx    (ix[j]),
            .tag    (tg[j])
          );
        end
      end
    end
  end

  assign tree_req[0] = req;
  assign any_req     = g_tree[0].g_lv[0].v[0];

  if (MODE == MODE_RR) begin : g_rr
    assign tree_req[1] = req & ({N{1'b1}} << ptr);
    assign use_hi      = g_tree[1].g_lv[0].v[0];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      ptr <= '0;
      else if (load_en) ptr <= win_idx + 1'b1;
    end
  end else begin : g_fixed
    assign use_hi = 1'b0;
    assign ptr    = '0;
  end

  assign win_idx = use_hi ? g_tree[NT-1].g_lv[0].ix[0] : g_tree[0].g_lv[0].ix[0];
  assign win_tag = use_hi ? g_tree[NT-1].g_lv[0].tg[0] : g_tree[0].g_lv[0].tg[0];

  // Gating with resetn keeps grant quiet while reset is held.
  assign load_en = resetn && !flush && (!out_valid || out_ready) && any_req;
  assign grant   = load_en ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;

  // ---- output register stage ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_tag   <= '0;
    end else if (load_en) begin
      out_valid <= 1'b1;
      out_idx   <= win_idx;
      out_tag   <= win_tag;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_select_rr.sv
// Directed bench for issue_select_rr: round-robin N=16 instance and fixed N=8 instance.
module tb_issue_select_rr;

  logic        clk;
  logic        resetn;

  logic [15:0] req1;
  logic [79:0] tag1;
  logic        flush1;
  logic [15:0] grant1;
  logic        valid1;
  logic        rdy1;
  logic [3:0]  idx1;
  logic [4:0]  otag1;

  logic [7:0]  req0;
  logic [39:0] tag0;
  logic        flush0;
  logic [7:0]  grant0;
  logic        valid0;
  logic        rdy0;
  logic [2:0]  idx0;
  logic [4:0]  otag0;

  int checks;
  int errors;

  issue_select_rr #(.N(16), .TAG_W(5), .MODE(1)) dut_rr (
    .clk(clk), .resetn(resetn), .req(req1), .tag(tag1), .flush(flush1),
    .grant(grant1), .out_valid(valid1), .out_ready(rdy1),
    .out_idx(idx1), .out_tag(otag1)
  );

  issue_select_rr #(.N(8), .TAG_W(5), .MODE(0)) dut_fx (
    .clk(clk), .resetn(resetn), .req(req0), .tag(tag0), .flush(flush0),
    .grant(grant0), .out_valid(valid0), .out_ready(rdy0),
    .out_idx(idx0), .out_tag(otag0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    req1 = '0; flush1 = 1'b0; rdy1 = 1'b0;
    req0 = '0; flush0 = 1'b0; rdy0 = 1'b0;
    for (int i = 0; i < 16; i++) tag1[i*5 +: 5] = 5'(10 + i);
    for (int i = 0; i < 8; i++)  tag0[i*5 +: 5] = 5'(10 + i);

    repeat (2) @(posedge clk);
    #2;
    req1 = 16'h8005;
    #1;
    chk("rst_grant", 32'(grant1), 32'h0);
    chk("rst_valid", 32'(valid1), 32'h0);
    chk("rst_idx", 32'(idx1), 32'h0);
    chk("rst_tag", 32'(otag1), 32'h0);
    chk("rst_valid_fx", 32'(valid0), 32'h0);

    // round-robin sweep over req = 0x8005
    #1; resetn = 1'b1; rdy1 = 1'b1;
    #1; chk("rr_g0", 32'(grant1), 32'h0001);
    tick();
    chk("rr_v0", 32'(valid1), 32'h1);
    chk("rr_i0", 32'(idx1), 32'd0);
    chk("rr_t0", 32'(otag1), 32'd10);
    #1; chk("rr_g1", 32'(grant1), 32'h0004);
    tick();
    chk("rr_i1", 32'(idx1), 32'd2);
    chk("rr_t1", 32'(otag1), 32'd12);
    #1; chk("rr_g2", 32'(grant1), 32'h8000);
    tick();
    chk("rr_i2", 32'(idx1), 32'd15);
    chk("rr_t2", 32'(otag1), 32'd25);
    #1; chk("rr_g3", 32'(grant1), 32'h0001);
    tick();
    chk("rr_i3", 32'(idx1), 32'd0);

    // drain: handshake with nothing to load
    req1 = 16'h0;
    #1; chk("drain_g", 32'(grant1), 32'h0);
    tick();
    chk("drain_v", 32'(valid1), 32'h0);
    chk("drain_idx_hold", 32'(idx1), 32'd0);

    // backpressure
    req1 = 16'h0010; rdy1 = 1'b0;
    #1; chk("bp_g_first", 32'(grant1), 32'h0010);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1; chk("bp_g_hold", 32'(grant1), 32'h0);
      tick();
      chk("bp_v", 32'(valid1), 32'h1);
      chk("bp_i", 32'(idx1), 32'd4);
      chk("bp_t", 32'(otag1), 32'd14);
    end

    // ptr should be 5: entry 5 beats entry 0
    req1 = 16'h0021; rdy1 = 1'b1;
    #1; chk("bp_ptr5_g", 32'(grant1), 32'h0020);
    tick();
    chk("bp_ptr5_i", 32'(idx1), 32'd5);

    // wrap-around
    req1 = 16'h4000;
    #1; chk("wr_g14", 32'(grant1), 32'h4000);
    tick();
    req1 = 16'h8001;
    #1; chk("wr_g15", 32'(grant1), 32'h8000);
    tick();
    chk("wr_i15", 32'(idx1), 32'd15);
    #1; chk("wr_g0", 32'(grant1), 32'h0001);
    tick();
    chk("wr_i0", 32'(idx1), 32'd0);

    // flush collides with handshake and requests; ptr stays 1
    req1 = 16'h00F0; flush1 = 1'b1;
    #1; chk("fl_g", 32'(grant1), 32'h0);
    tick();
    chk("fl_v", 32'(valid1), 32'h0);
    chk("fl_idx_hold", 32'(idx1), 32'd0);
    flush1 = 1'b0;
    #1; chk("fl_after_g", 32'(grant1), 32'h0010);
    tick();
    chk("fl_after_i", 32'(idx1), 32'd4);
    chk("fl_after_v", 32'(valid1), 32'h1);

    // reset mid-stream; ptr was 5, after reset it restarts at 0
    #1; resetn = 1'b0;
    #1;
    chk("mr_v", 32'(valid1), 32'h0);
    chk("mr_g", 32'(grant1), 32'h0);
    tick();
    resetn = 1'b1;
    #1; chk("mr_first_g", 32'(grant1), 32'h0010);
    tick();
    chk("mr_first_i", 32'(idx1), 32'd4);
    chk("mr_first_t", 32'(otag1), 32'd14);

    // fixed priority, N=8
    req0 = 8'h81; rdy0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; chk("fx_g", 32'(grant0), 32'h01);
      tick();
      chk("fx_i", 32'(idx0), 32'd0);
      chk("fx_t", 32'(otag0), 32'd10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
